// File: rtl/cpu_bram_responder_if.sv
// TG68-style CPU port between the requester (sdram_ctrl side) and the block-RAM responder.
interface cpu_bram_responder_if #(
    parameter int CPU_ADDR_BITS = 26
);
    logic [CPU_ADDR_BITS-1:1] cpuAddr;
    logic [3:0]               cpustate;
    logic                     cpuL;
    logic                     cpuU;
    logic [15:0]              cpuWR;
    logic [15:0]              cpuRD;
    logic                     cpuena;
    logic                     hit;

    modport master (
        output cpuAddr, cpustate, cpuL, cpuU, cpuWR,
        input  cpuRD, cpuena, hit
    );

    modport slave (
        input  cpuAddr, cpustate, cpuL, cpuU, cpuWR,
        output cpuRD, cpuena, hit
    );
endinterface

// File: rtl/cpu_bram_responder.sv
// Block-RAM fast-memory responder on the TG68 CPU port, with wait states and a one-word read-ahead buffer.
//
// state | meaning
// IDLE  | waiting for a selected request; sampling inputs, completing any pending read-ahead
// WAIT  | wait-state down-counter running; RAM read data settling
// ACK   | cpuena high for one cycle; write committed, read-ahead launched if longword read
// HOLD  | access done; waiting for the requester to release the bus
module cpu_bram_responder #(
    parameter int CPU_ADDR_BITS = 26,
    parameter int ADDR_BITS     = 12,
    parameter int BASE          = 0,
    parameter int WAIT_STATES   = 2
) (
    input  logic                 sysclk,
    input  logic                 reset_in,
    cpu_bram_responder_if.slave  bus
);
    localparam int             PFX_W     = CPU_ADDR_BITS - ADDR_BITS - 1;
    localparam logic [PFX_W-1:0] BASE_P  = PFX_W'(BASE);
    localparam logic [3:0]     WAIT_INIT = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

    state_t                 state_q;
    logic [3:0]             cnt_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   wr_q;
    logic                   long_q;
    logic                   stb_l_q;
    logic                   stb_u_q;
    logic [15:0]            wdata_q;
    logic [15:0]            rd_q;
    logic                   ena_q;
    logic [15:0]            pbuf_q;
    logic [ADDR_BITS-1:0]   pbuf_tag_q;
    logic                   pbuf_valid_q;
    logic                   fill_q;
    logic [15:0]            ram_q;
    logic [ADDR_BITS-1:0]   raddr_d;

    logic                   req_c;
    logic                   sel_c;
    logic                   is_read_c;
    logic                   pbuf_match_c;
    logic                   released_c;
    logic                   we_c;
    logic [ADDR_BITS-1:0]   idx_c;

    logic [15:0] mem [2**ADDR_BITS];

    assign idx_c        = bus.cpuAddr[ADDR_BITS:1];
    assign req_c        = !bus.cpustate[2] && (bus.cpustate[1:0] != 2'b01);
    assign sel_c        = req_c && (bus.cpuAddr[CPU_ADDR_BITS-1:ADDR_BITS+1] == BASE_P);
    assign is_read_c    = (bus.cpustate[1:0] != 2'b11);
    assign pbuf_match_c = is_read_c && pbuf_valid_q && (idx_c == pbuf_tag_q);
    assign released_c   = bus.cpustate[2] || (bus.cpustate[1:0] == 2'b01);
    assign we_c         = (state_q == S_WAIT) && (cnt_q == 4'd0) && wr_q;

    assign bus.hit    = sel_c;
    assign bus.cpuRD  = rd_q;
    assign bus.cpuena = ena_q;

    // The single read port follows the request in IDLE, holds the access word
    // through WAIT, and fetches the read-ahead word while in ACK.
    always_comb begin
        raddr_d = addr_q;
        case (state_q)
            S_IDLE:  raddr_d = idx_c;
            S_ACK:   raddr_d = addr_q + 1'b1;
            default: raddr_d = addr_q;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (we_c && !stb_l_q) mem[addr_q][7:0]  <= wdata_q[7:0];
        if (we_c && !stb_u_q) mem[addr_q][15:8] <= wdata_q[15:8];
        ram_q <= mem[raddr_d];
    end

    always_ff @(posedge sysclk or posedge reset_in) begin
        if (reset_in) begin
            state_q      <= S_IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= '0;
            wr_q         <= 1'b0;
            long_q       <= 1'b0;
            stb_l_q      <= 1'b1;
            stb_u_q      <= 1'b1;
            wdata_q      <= 16'h0000;
            rd_q         <= 16'h0000;
            ena_q        <= 1'b0;
            pbuf_q       <= 16'h0000;
            pbuf_tag_q   <= '0;
            pbuf_valid_q <= 1'b0;
            fill_q       <= 1'b0;
        end else begin
            ena_q <= 1'b0;

            // Read-ahead lands one cycle after ACK unless a new request preempts it.
            if (fill_q && !(state_q == S_IDLE && sel_c)) begin
                fill_q       <= 1'b0;
                pbuf_q       <= ram_q;
                pbuf_tag_q   <= addr_q + 1'b1;
                pbuf_valid_q <= 1'b1;
            end

            case (state_q)
                S_IDLE: begin
                    if (sel_c) begin
                        addr_q  <= idx_c;
                        wr_q    <= !is_read_c;
                        long_q  <= bus.cpustate[3];
                        stb_l_q <= bus.cpuL;
                        stb_u_q <= bus.cpuU;
                        wdata_q <= bus.cpuWR;
                        fill_q  <= 1'b0;
                        if (pbuf_match_c) begin
                            rd_q    <= pbuf_q;
                            ena_q   <= 1'b1;
                            state_q <= S_ACK;
                        end else begin
                            pbuf_valid_q <= 1'b0;
                            cnt_q        <= WAIT_INIT;
                            state_q      <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        if (!wr_q) rd_q <= ram_q;
                        ena_q   <= 1'b1;
                        state_q <= S_ACK;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_ACK: begin
                    if (!wr_q && long_q && !(&addr_q)) begin
                        fill_q       <= 1'b1;
                        pbuf_valid_q <= 1'b0;
                    end
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    if (released_c) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_bram_responder.sv
// Scoreboard bench for cpu_bram_responder: directed scenarios then randomized traffic against a memory/prefetch model.
module tb_cpu_bram_responder;
    localparam int CAB = 26;
    localparam int AB  = 12;
    localparam int WS  = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    cpu_bram_responder_if #(.CPU_ADDR_BITS(CAB)) bus ();

    cpu_bram_responder #(
        .CPU_ADDR_BITS(CAB), .ADDR_BITS(AB), .BASE(0), .WAIT_STATES(WS)
    ) dut (
        .sysclk   (clk),
        .reset_in (rst),
        .bus      (bus)
    );

    typedef struct {
        int          lat;
        logic [15:0] data;
        logic [15:0] mask;
        int          issue;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int acks  = 0;

    // Reference model: word contents, per-byte knowledge, and the prefetched word (if any).
    logic [15:0] mdl_mem [4096];
    bit          known_lo [4096];
    bit          known_hi [4096];
    bit          pf_valid = 1'b0;
    logic [11:0] pf_addr  = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (bus.cpuena === 1'b1) begin
            acks++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_ack: cpuena=1 at cycle %0d, expected 0 (nothing outstanding)", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("ack_latency", 32'(cyc - mon_e.issue + 1), 32'(mon_e.lat));
                if (mon_e.mask != 16'h0000)
                    check("read_data", 32'(bus.cpuRD & mon_e.mask), 32'(mon_e.data & mon_e.mask));
            end
        end
    end

    task automatic do_req(input logic [11:0] a, input logic [1:0] st, input bit lw,
                          input bit l_n, input bit u_n, input logic [15:0] wd,
                          input logic [12:0] pfx, input int hold_extra, input int watch);
        exp_t e;
        int   a0;
        bit   is_rd;
        bit   pfh;
        bit   done;
        @(negedge clk);
        bus.cpuAddr  = {pfx, a};
        bus.cpustate = {lw, 1'b0, st};
        bus.cpuL     = l_n;
        bus.cpuU     = u_n;
        bus.cpuWR    = wd;
        #1;
        check("hit_decode", 32'(bus.hit), 32'(pfx == 13'd0));
        a0 = acks;
        if (pfx != 13'd0) begin
            repeat (watch) @(negedge clk);
            #1;
            check("foreign_no_ack", 32'(acks - a0), 32'd0);
        end else begin
            is_rd   = (st != 2'b11);
            pfh     = is_rd && pf_valid && (a == pf_addr);
            e.lat   = pfh ? 1 : 1 + WS;
            e.issue = cyc + 1;
            e.data  = mdl_mem[a];
            e.mask  = is_rd ? {{8{known_hi[a]}}, {8{known_lo[a]}}} : 16'h0000;
            sb.push_back(e);
            if (!is_rd) begin
                if (!l_n) begin mdl_mem[a][7:0]  = wd[7:0];  known_lo[a] = 1'b1; end
                if (!u_n) begin mdl_mem[a][15:8] = wd[15:8]; known_hi[a] = 1'b1; end
                pf_valid = 1'b0;
            end else if (!pfh) begin
                pf_valid = 1'b0;
            end
            if (is_rd && lw && a != 12'hFFF) begin
                pf_valid = 1'b1;
                pf_addr  = a + 12'd1;
            end
            done = 1'b0;
            for (int i = 0; i < 40 && !done; i++) begin
                @(negedge clk);
                #1;
                if (acks != a0) done = 1'b1;
            end
            if (!done) begin
                n_cmp++;
                n_bad++;
                $display("FAIL ack_timeout: no cpuena within 40 cycles for addr 0x%0h, expected one", a);
                sb.delete();
            end
            repeat (hold_extra) @(negedge clk);
        end
        bus.cpustate = 4'b0101;
        repeat (2) @(negedge clk);
        #1;
        if (pfx == 13'd0) check("single_ack", 32'(acks - a0), 32'd1);
    endtask

    task automatic reset_mid(input logic [11:0] a, input logic [15:0] wd);
        int a0;
        @(negedge clk);
        bus.cpuAddr  = {13'd0, a};
        bus.cpustate = 4'b0011;
        bus.cpuL     = 1'b0;
        bus.cpuU     = 1'b0;
        bus.cpuWR    = wd;
        a0 = acks;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        bus.cpustate = 4'b0101;
        #1;
        check("midreset_cpuena", 32'(bus.cpuena), 32'd0);
        check("midreset_cpuRD", 32'(bus.cpuRD), 32'd0);
        rst = 1'b0;
        pf_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("midreset_no_ack", 32'(acks - a0), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int          a0;
        logic [11:0] ra;
        logic [1:0]  rst_sel;
        logic [12:0] rp;

        rst          = 1'b1;
        bus.cpuAddr  = '0;
        bus.cpustate = 4'b0101;
        bus.cpuL     = 1'b1;
        bus.cpuU     = 1'b1;
        bus.cpuWR    = 16'h0000;

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("reset_cpuena", 32'(bus.cpuena), 32'd0);
        rst = 1'b0;
        #1;
        check("postreset_cpuena", 32'(bus.cpuena), 32'd0);
        check("postreset_cpuRD", 32'(bus.cpuRD), 32'd0);
        a0 = acks;
        repeat (10) @(negedge clk);
        #1;
        check("idle_no_ack", 32'(acks - a0), 32'd0);

        // Full-word write and read-back
        do_req(12'h010, 2'b11, 1'b0, 1'b0, 1'b0, 16'hA5C3, 13'd0, 0, 0);
        do_req(12'h010, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);

        // Byte strobes, including a write with neither byte enabled
        do_req(12'h020, 2'b11, 1'b0, 1'b0, 1'b0, 16'hFFFF, 13'd0, 0, 0);
        do_req(12'h020, 2'b11, 1'b0, 1'b0, 1'b1, 16'h1234, 13'd0, 0, 0);
        do_req(12'h020, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h020, 2'b11, 1'b0, 1'b1, 1'b1, 16'h0BAD, 13'd0, 0, 0);
        do_req(12'h020, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);

        // Longword read: second half served from the read-ahead buffer
        do_req(12'h030, 2'b11, 1'b0, 1'b0, 1'b0, 16'h1111, 13'd0, 0, 0);
        do_req(12'h031, 2'b11, 1'b0, 1'b0, 1'b0, 16'h2222, 13'd0, 0, 0);
        do_req(12'h030, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h031, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h030, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h100, 2'b11, 1'b0, 1'b0, 1'b0, 16'h5555, 13'd0, 0, 0);
        do_req(12'h031, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h030, 2'b00, 1'b1, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h031, 2'b00, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);

        // Foreign prefix, and no read-ahead wrap past the last word
        do_req(12'h010, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'h0001, 0, 50);
        do_req(12'hFFF, 2'b10, 1'b1, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);
        do_req(12'h000, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);

        // Request held long after ack, then reset in the middle of a write
        do_req(12'h010, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 10, 0);
        reset_mid(12'h010, 16'hDEAD);
        do_req(12'h010, 2'b10, 1'b0, 1'b1, 1'b1, 16'h0000, 13'd0, 0, 0);

        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: ra = pf_valid ? pf_addr : 12'($urandom_range(0, 15));
                3:       ra = 12'hFFF - 12'($urandom_range(0, 1));
                default: ra = 12'($urandom_range(0, 15));
            endcase
            case ($urandom_range(0, 2))
                0:       rst_sel = 2'b00;
                1:       rst_sel = 2'b10;
                default: rst_sel = 2'b11;
            endcase
            rp = ($urandom_range(0, 9) == 0) ? 13'($urandom_range(1, 8191)) : 13'd0;
            do_req(ra, rst_sel, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 16'($urandom), rp, $urandom_range(0, 3), 6);
        end

        repeat (5) @(negedge clk);
        #1;
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
